// File: rtl/lcd_hd44780_ctrl_if.sv
`timescale 1ns/1ps
// Avalon-MM slave bus carried between the Nios II fabric and the HD44780 sequencer.
interface lcd_hd44780_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
`timescale 1ns/1ps
// HD44780 4-bit mode sequencer: queued command/data/nibble entries are split into
// nibbles and strobed onto the LCD pins with setup, E-high, hold and execution waits.
module lcd_hd44780_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned E_HIGH_CYC   = 25,
    parameter int unsigned HOLD_CYC     = 25,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    lcd_hd44780_ctrl_if.slave        bus,
    output logic                     lcd_rs,
    output logic                     lcd_rw,
    output logic                     lcd_e,
    output logic [3:0]               lcd_db,
    output logic                     irq
);
    localparam int unsigned AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = (CLR_WAIT_CYC > 2) ? $clog2(CLR_WAIT_CYC) : 1;

    localparam logic [CNTW-1:0] DEPTH_L  = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0]   LD_EHIGH = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0]   LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]   LD_CMD   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0]   LD_CLR   = CW'(CLR_WAIT_CYC - 1);

    localparam logic [1:0] K_CMD  = 2'b00;
    localparam logic [1:0] K_DATA = 2'b01;
    localparam logic [1:0] K_NIB  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_WAIT} state_t;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            ovf;
    logic            wr_en, push_req, push_ok, pop, full, empty, busy;
    logic [9:0]      push_entry, head;
    logic [4:0]      count_ext;
    logic [2:0]      level_disp;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      cur_kind, kind_n;
    logic [7:0]      cur_byte, byte_n;
    logic            second, second_n;
    logic            rs_n, e_n, clr_cmd;
    logic [3:0]      db_n;

    assign wr_en    = bus.chipselect & ~bus.write_n;
    assign push_req = wr_en & (bus.address != 2'd2);
    assign full     = (count == DEPTH_L);
    assign empty    = (count == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok  = push_req & (~full | pop);
    assign head     = mem[rd_ptr];
    assign busy     = (state != S_IDLE) | ~empty;
    assign irq      = ~busy;
    assign lcd_rw   = 1'b0;

    always_comb begin
        push_entry = '0;
        case (bus.address)
            2'd0:    push_entry = {K_CMD,  bus.writedata[7:0]};
            2'd1:    push_entry = {K_DATA, bus.writedata[7:0]};
            2'd3:    push_entry = {K_NIB,  4'h0, bus.writedata[3:0]};
            default: push_entry = '0;
        endcase
    end

    always_comb begin
        count_ext     = 5'(count);
        level_disp    = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
        bus.readdata  = '0;
        if (bus.address == 2'd2)
            bus.readdata = {25'b0, level_disp, 1'b0, ovf, full, busy};
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (pop && !push_ok)
                count <= count - 1'b1;
            if (push_req && !push_ok)
                ovf <= 1'b1;
            else if (wr_en && bus.address == 2'd2 && bus.writedata[0])
                ovf <= 1'b0;
        end
    end

    assign clr_cmd = (cur_kind == K_CMD) && (cur_byte >= 8'd1) && (cur_byte <= 8'd3);

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
        kind_n   = cur_kind;
        byte_n   = cur_byte;
        second_n = second;
        rs_n     = lcd_rs;
        db_n     = lcd_db;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    kind_n   = head[9:8];
                    byte_n   = head[7:0];
                    rs_n     = (head[9:8] == K_DATA);
                    second_n = (head[9:8] != K_NIB);
                    db_n     = (head[9:8] == K_NIB) ? head[3:0] : head[7:4];
                    cnt_n    = LD_SETUP;
                    state_n  = S_SETUP;
                end
            end
            S_SETUP: if (cnt == '0) begin
                cnt_n   = LD_EHIGH;
                state_n = S_EHIGH;
            end
            S_EHIGH: if (cnt == '0) begin
                cnt_n   = LD_HOLD;
                state_n = S_HOLD;
            end
            S_HOLD: if (cnt == '0) begin
                if (second) begin
                    second_n = 1'b0;
                    db_n     = cur_byte[3:0];
                    cnt_n    = LD_SETUP;
                    state_n  = S_SETUP;
                end else begin
                    cnt_n    = clr_cmd ? LD_CLR : LD_CMD;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: if (cnt == '0)
                state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        e_n = (state_n == S_EHIGH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_kind <= '0;
            cur_byte <= '0;
            second   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= '0;
            lcd_e    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_kind <= kind_n;
            cur_byte <= byte_n;
            second   <= second_n;
            lcd_rs   <= rs_n;
            lcd_db   <= db_n;
            lcd_e    <= e_n;
        end
    end
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
`timescale 1ns/1ps
// Bench for lcd_hd44780_ctrl: LCD strobe timing and nibble content are compared
// against a per-entry timing model built from the byte period rules.
module tb_lcd_hd44780_ctrl;
    localparam int SETUP = 4;
    localparam int EH    = 25;
    localparam int HOLD  = 25;
    localparam int CMD_W = 2000;
    localparam int CLR_W = 3000;
    localparam int PER   = SETUP + EH + HOLD;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e, irq;
    logic [3:0] lcd_db;

    lcd_hd44780_ctrl_if bus();

    lcd_hd44780_ctrl #(
        .FIFO_DEPTH  (4),
        .SETUP_CYC   (SETUP),
        .E_HIGH_CYC  (EH),
        .HOLD_CYC    (HOLD),
        .CMD_WAIT_CYC(CMD_W),
        .CLR_WAIT_CYC(CLR_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_db (lcd_db),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int         rise_cyc[$];
    int         fall_cyc[$];
    logic       rise_rs[$];
    logic [3:0] rise_db[$];
    logic       prev_e = 1'b0;

    always @(posedge clk) begin
        #1;
        if (lcd_e && !prev_e) begin
            rise_cyc.push_back(cyc);
            rise_rs.push_back(lcd_rs);
            rise_db.push_back(lcd_db);
        end
        if (!lcd_e && prev_e)
            fall_cyc.push_back(cyc);
        prev_e = lcd_e;
    end

    typedef struct {
        int         wt;
        logic [1:0] kind;
        logic [7:0] b;
    } ent_t;

    ent_t       ents[$];
    int         exp_rise[$];
    int         exp_fall[$];
    logic       exp_rs[$];
    logic [3:0] exp_db[$];
    int         exp_idle;

    // Each entry starts one cycle after the later of its write and the previous idle point.
    function automatic void build_model();
        int t_free, s, n, w, r;
        exp_rise.delete(); exp_fall.delete(); exp_rs.delete(); exp_db.delete();
        t_free = 0;
        foreach (ents[i]) begin
            s = ents[i].wt + 1;
            if (t_free + 1 > s) s = t_free + 1;
            n = (ents[i].kind == 2'd2) ? 1 : 2;
            for (int k = 0; k < n; k++) begin
                r = s + SETUP + k * PER;
                exp_rise.push_back(r);
                exp_fall.push_back(r + EH);
                exp_rs.push_back(ents[i].kind == 2'd1);
                exp_db.push_back((n == 2 && k == 0) ? ents[i].b[7:4] : ents[i].b[3:0]);
            end
            w = (ents[i].kind == 2'd0 && ents[i].b >= 8'd1 && ents[i].b <= 8'd3) ? CLR_W : CMD_W;
            t_free = s + n * PER + w;
        end
        exp_idle = t_free;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic push_ent(input logic [1:0] kind, input logic [7:0] b);
        logic [1:0] a;
        ent_t e;
        a = (kind == 2'd0) ? 2'd0 : (kind == 2'd1) ? 2'd1 : 2'd3;
        bus_write(a, {24'h0, b});
        e.wt   = cyc;
        e.kind = kind;
        e.b    = (kind == 2'd2) ? {4'h0, b[3:0]} : b;
        ents.push_back(e);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < budget; i++) begin
            if (irq) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic clear_capture();
        rise_cyc.delete(); fall_cyc.delete(); rise_rs.delete(); rise_db.delete();
        ents.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        bus_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=00000000", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b want=1", irq); end
        total++; if ({lcd_rs, lcd_rw, lcd_e} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {lcd_rs, lcd_rw, lcd_e}); end
        total++; if (lcd_db !== 4'h0) begin bad++; $display("FAIL reset_db got=%h want=0", lcd_db); end
    endtask

    task automatic test_data_byte();
        int t; bit ok;
        clear_capture();
        push_ent(2'd1, 8'h41);
        tick();
        total++; if (lcd_rs !== 1'b1 || lcd_db !== 4'h4) begin bad++; $display("FAIL data_first_nibble got rs=%b db=%h want rs=1 db=4", lcd_rs, lcd_db); end
        wait_idle(4000, t, ok);
        build_model();
        total++; if (!ok || t !== exp_idle) begin bad++; $display("FAIL data_idle_time got=%0d want=%0d", t, exp_idle); end
        total++;
        if (rise_cyc.size() != exp_rise.size() || fall_cyc.size() != exp_fall.size()) begin
            bad++; $display("FAIL data_pulse_count got=%0d/%0d want=%0d", rise_cyc.size(), fall_cyc.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size() && i < rise_cyc.size() && i < fall_cyc.size(); i++) begin
            total++;
            if (rise_cyc[i] !== exp_rise[i] || fall_cyc[i] !== exp_fall[i] || rise_rs[i] !== exp_rs[i] || rise_db[i] !== exp_db[i]) begin
                bad++; $display("FAIL data_pulse%0d got rise=%0d fall=%0d rs=%b db=%h want rise=%0d fall=%0d rs=%b db=%h",
                    i, rise_cyc[i], fall_cyc[i], rise_rs[i], rise_db[i], exp_rise[i], exp_fall[i], exp_rs[i], exp_db[i]);
            end
        end
    endtask

    task automatic test_clear_and_nibble();
        int t; bit ok;
        clear_capture();
        push_ent(2'd0, 8'h01);
        push_ent(2'd1, 8'($urandom_range(0, 255)));
        push_ent(2'd2, 8'h03);
        push_ent(2'd1, 8'($urandom_range(0, 255)));
        wait_idle(15000, t, ok);
        build_model();
        total++; if (!ok || t !== exp_idle) begin bad++; $display("FAIL clrnib_idle_time got=%0d want=%0d", t, exp_idle); end
        total++;
        if (rise_cyc.size() != exp_rise.size() || fall_cyc.size() != exp_fall.size()) begin
            bad++; $display("FAIL clrnib_pulse_count got=%0d/%0d want=%0d", rise_cyc.size(), fall_cyc.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size() && i < rise_cyc.size() && i < fall_cyc.size(); i++) begin
            total++;
            if (rise_cyc[i] !== exp_rise[i] || fall_cyc[i] !== exp_fall[i] || rise_rs[i] !== exp_rs[i] || rise_db[i] !== exp_db[i]) begin
                bad++; $display("FAIL clrnib_pulse%0d got rise=%0d fall=%0d rs=%b db=%h want rise=%0d fall=%0d rs=%b db=%h",
                    i, rise_cyc[i], fall_cyc[i], rise_rs[i], rise_db[i], exp_rise[i], exp_fall[i], exp_rs[i], exp_db[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t; bit ok;
        logic [31:0] d;
        clear_capture();
        for (int i = 0; i < 5; i++)
            push_ent(2'd1, 8'($urandom_range(0, 255)));
        bus_write(2'd1, 32'($urandom_range(0, 255)));
        bus_read(2'd2, d);
        total++; if (d !== 32'h47) begin bad++; $display("FAIL ovf_status got=%h want=00000047", d); end
        bus_read(2'd0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL addr0_read got=%h want=00000000", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL busy_irq got=%b want=0", irq); end
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, d);
        total++; if (d[2] !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", d[2]); end
        wait_idle(15000, t, ok);
        build_model();
        total++; if (!ok || t !== exp_idle) begin bad++; $display("FAIL b2b_idle_time got=%0d want=%0d", t, exp_idle); end
        total++;
        if (rise_cyc.size() != exp_rise.size() || fall_cyc.size() != exp_fall.size()) begin
            bad++; $display("FAIL b2b_pulse_count got=%0d/%0d want=%0d", rise_cyc.size(), fall_cyc.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size() && i < rise_cyc.size() && i < fall_cyc.size(); i++) begin
            total++;
            if (rise_cyc[i] !== exp_rise[i] || fall_cyc[i] !== exp_fall[i] || rise_rs[i] !== exp_rs[i] || rise_db[i] !== exp_db[i]) begin
                bad++; $display("FAIL b2b_pulse%0d got rise=%0d fall=%0d rs=%b db=%h want rise=%0d fall=%0d rs=%b db=%h",
                    i, rise_cyc[i], fall_cyc[i], rise_rs[i], rise_db[i], exp_rise[i], exp_fall[i], exp_rs[i], exp_db[i]);
            end
        end
    endtask

    task automatic test_random();
        int t; bit ok;
        logic [1:0] kind;
        logic [7:0] b;
        for (int round = 0; round < 2; round++) begin
            clear_capture();
            for (int i = 0; i < 4; i++) begin
                kind = 2'($urandom_range(0, 2));
                b    = 8'($urandom_range(0, 255));
                if (kind == 2'd0 && $urandom_range(0, 1) == 1)
                    b = 8'($urandom_range(1, 3));
                push_ent(kind, b);
                repeat ($urandom_range(0, 200)) tick();
            end
            wait_idle(20000, t, ok);
            build_model();
            total++; if (!ok || t !== exp_idle) begin bad++; $display("FAIL rand%0d_idle_time got=%0d want=%0d", round, t, exp_idle); end
            total++;
            if (rise_cyc.size() != exp_rise.size() || fall_cyc.size() != exp_fall.size()) begin
                bad++; $display("FAIL rand%0d_pulse_count got=%0d/%0d want=%0d", round, rise_cyc.size(), fall_cyc.size(), exp_rise.size());
            end
            for (int i = 0; i < exp_rise.size() && i < rise_cyc.size() && i < fall_cyc.size(); i++) begin
                total++;
                if (rise_cyc[i] !== exp_rise[i] || fall_cyc[i] !== exp_fall[i] || rise_rs[i] !== exp_rs[i] || rise_db[i] !== exp_db[i]) begin
                    bad++; $display("FAIL rand%0d_pulse%0d got rise=%0d fall=%0d rs=%b db=%h want rise=%0d fall=%0d rs=%b db=%h",
                        round, i, rise_cyc[i], fall_cyc[i], rise_rs[i], rise_db[i], exp_rise[i], exp_fall[i], exp_rs[i], exp_db[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit seen;
        clear_capture();
        for (int i = 0; i < 3; i++)
            push_ent(2'd1, 8'($urandom_range(0, 255)));
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (lcd_e) begin seen = 1'b1; break; end
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL midrst_e_rise got=0 want=1"); end
        repeat (2) tick();
        #1 reset_n = 1'b0;
        #1;
        total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL midrst_e_drop got=%b want=0", lcd_e); end
        bus_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_status got=%h want=00000000", d); end
        tick();
        reset_n = 1'b1;
        clear_capture();
        repeat (300) tick();
        total++; if (rise_cyc.size() != 0) begin bad++; $display("FAIL midrst_no_pulse got=%0d want=0", rise_cyc.size()); end
        total++; if (irq !== 1'b1 || {lcd_rs, lcd_e, lcd_db} !== 6'h0) begin bad++; $display("FAIL midrst_idle got irq=%b pins=%h want irq=1 pins=00", irq, {lcd_rs, lcd_e, lcd_db}); end
    endtask

    initial begin
        test_reset();
        test_data_byte();
        test_clear_and_nibble();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
